// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers used by the iterative inverse cipher.
package aes_pkg;

    // The largest key schedule (AES-256) holds 4*(14+1) words.
    localparam int MAX_WORDS = 60;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        READY,
        ROUND,
        DONE
    } aes_state_e;

    // Element 0 sits in the leftmost bits, so SBOX[x] returns the entry for byte x.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[x];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Round constants; only indices 1..10 are ever used.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Key, ciphertext and plaintext valid/ready channels of the iterative AES decryptor.
interface aes_decrypt_iter_if #(
    parameter int KEY_LEN = 128
);
    logic               key_valid;
    logic [KEY_LEN-1:0] key_in;
    logic               key_ready;
    logic               in_valid;
    logic [127:0]       ciphertext;
    logic               in_ready;
    logic               out_valid;
    logic [127:0]       plaintext;
    logic               out_ready;

    // Source/sink side.
    modport master (
        output key_valid, key_in, in_valid, ciphertext, out_ready,
        input  key_ready, in_ready, out_valid, plaintext
    );

    // Decryptor side.
    modport slave (
        input  key_valid, key_in, in_valid, ciphertext, out_ready,
        output key_ready, in_ready, out_valid, plaintext
    );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3),
                mul_09(a0) ^ mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3),
                mul_0d(a0) ^ mul_09(a1) ^ mul_0e(a2) ^ mul_0b(a3),
                mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2) ^ mul_0e(a3)};
    endfunction

    logic [127:0] subbed;
    logic [127:0] added;

    // Byte k is row k%4, column k/4; row r rotates right by r columns.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        subbed    = '0;
        added     = '0;
        state_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                subbed[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(state_in[127 - 8*(4*((c - r) & 3) + r) -: 8]);
            end
        end
        added = subbed ^ round_key;
        for (int c = 0; c < 4; c++) begin
            state_out[127 - 32*c -: 32] = last ? added[127 - 32*c -: 32]
                                               : inv_mix_col(added[127 - 32*c -: 32]);
        end
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128/192/256 decryptor: expands the key once into a word store,
// then runs one inverse round per clock for each handshaked block.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int KEY_LEN = 128,
    parameter int NR      = 10,
    parameter int NK      = 4
) (
    input  logic             clk,
    input  logic             rst,
    aes_decrypt_iter_if.slave bus
);

    localparam int              TOTAL     = 4 * (NR + 1);
    localparam int              WW        = $clog2(MAX_WORDS);
    localparam logic [WW-1:0]   LAST_WORD = WW'(TOTAL - 1);
    localparam logic [WW-1:0]   NK_W      = WW'(NK);
    localparam logic [2:0]      NK_M1     = 3'(NK - 1);
    localparam logic [3:0]      NR_M1     = 4'(NR - 1);

    aes_state_e     state_q, state_d;
    logic [31:0]    w [TOTAL];
    logic [WW-1:0]  word_idx;
    logic [2:0]     kpos;       // word_idx mod NK
    logic [3:0]     rcon_idx;   // word_idx / NK
    logic [3:0]     cnt;
    logic [127:0]   st;
    logic [127:0]   pt_q;
    logic           key_rdy, in_rdy, key_fire, blk_fire;
    logic [WW-1:0]  prev_idx, back_idx;
    logic [31:0]    temp;
    logic [127:0]   rk_cur, rk_last, round_out;

    assign prev_idx = word_idx - WW'(1);
    assign back_idx = word_idx - NK_W;
    assign rk_cur   = {w[{cnt, 2'b00}], w[{cnt, 2'b01}], w[{cnt, 2'b10}], w[{cnt, 2'b11}]};
    assign rk_last  = {w[4*NR], w[4*NR + 1], w[4*NR + 2], w[4*NR + 3]};

    aes_inv_round u_round (
        .state_in  (st),
        .round_key (rk_cur),
        .last      (cnt == 4'd0),
        .state_out (round_out)
    );

    // Key-schedule mixing term for the word being generated.
    always_comb begin
        temp = w[prev_idx];
        if (kpos == 3'd0)
            temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon(rcon_idx), 24'h0};
        else if (NK > 6 && kpos == 3'd4)
            temp = sub_word(temp);
    end

    // Next state and handshake readies; a key offered in READY beats a block.
    always_comb begin
        key_rdy  = (state_q == IDLE) || (state_q == READY);
        in_rdy   = (state_q == READY) && !bus.key_valid;
        key_fire = bus.key_valid && key_rdy;
        blk_fire = bus.in_valid && in_rdy;
        state_d  = state_q;
        case (state_q)
            IDLE:    if (key_fire) state_d = KEYEXP;
            KEYEXP:  if (word_idx == LAST_WORD) state_d = READY;
            READY:   if (key_fire) state_d = KEYEXP;
                     else if (blk_fire) state_d = ROUND;
            ROUND:   if (cnt == 4'd0) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = READY;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Expansion counters, block state, round counter and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx <= '0;
            kpos     <= '0;
            rcon_idx <= '0;
            cnt      <= '0;
            st       <= '0;
            pt_q     <= '0;
        end else begin
            if (key_fire) begin
                word_idx <= NK_W;
                kpos     <= '0;
                rcon_idx <= 4'd1;
            end else if (state_q == KEYEXP) begin
                word_idx <= word_idx + WW'(1);
                if (kpos == NK_M1) begin
                    kpos     <= '0;
                    rcon_idx <= rcon_idx + 4'd1;
                end else begin
                    kpos <= kpos + 3'd1;
                end
            end
            if (blk_fire) begin
                st  <= bus.ciphertext ^ rk_last;
                cnt <= NR_M1;
            end else if (state_q == ROUND) begin
                st  <= round_out;
                cnt <= cnt - 4'd1;
                if (cnt == 4'd0) pt_q <= round_out;
            end
        end
    end

    // Round-key word store, loaded on key accept and filled one word per KEYEXP cycle.
    always_ff @(posedge clk) begin
        // NOTE: the word store has no reset; the FSM sits in IDLE until a key has been expanded.
        if (key_fire) begin
            for (int j = 0; j < NK; j++) w[j] <= bus.key_in[KEY_LEN - 1 - 32*j -: 32];
        end else if (state_q == KEYEXP) begin
            w[word_idx] <= w[back_idx] ^ temp;
        end
    end

    assign bus.key_ready = key_rdy;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == DONE);
    assign bus.plaintext = pt_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: FIPS-197 vectors for all three key sizes,
// key-expansion and block latency, backpressure, key priority and mid-round reset.
module tb_aes_decrypt_iter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_decrypt_iter_if #(.KEY_LEN(128)) b128 ();
    aes_decrypt_iter_if #(.KEY_LEN(192)) b192 ();
    aes_decrypt_iter_if #(.KEY_LEN(256)) b256 ();

    aes_decrypt_iter #(.KEY_LEN(128), .NR(10), .NK(4)) u128 (.clk(clk), .rst(rst), .bus(b128.slave));
    aes_decrypt_iter #(.KEY_LEN(192), .NR(12), .NK(6)) u192 (.clk(clk), .rst(rst), .bus(b192.slave));
    aes_decrypt_iter #(.KEY_LEN(256), .NR(14), .NK(8)) u256 (.clk(clk), .rst(rst), .bus(b256.slave));

    logic         kv [3];
    logic         iv [3];
    logic         ordy [3];
    logic [255:0] key_s;     // key left-aligned; each instance takes its top KEY_LEN bits
    logic [127:0] ct_s;
    logic         kr [3];
    logic         ir [3];
    logic         ov [3];
    logic [127:0] pt [3];

    assign b128.key_valid = kv[0];
    assign b128.key_in    = key_s[255:128];
    assign b128.in_valid  = iv[0];
    assign b128.ciphertext = ct_s;
    assign b128.out_ready = ordy[0];
    assign kr[0] = b128.key_ready;
    assign ir[0] = b128.in_ready;
    assign ov[0] = b128.out_valid;
    assign pt[0] = b128.plaintext;

    assign b192.key_valid = kv[1];
    assign b192.key_in    = key_s[255:64];
    assign b192.in_valid  = iv[1];
    assign b192.ciphertext = ct_s;
    assign b192.out_ready = ordy[1];
    assign kr[1] = b192.key_ready;
    assign ir[1] = b192.in_ready;
    assign ov[1] = b192.out_valid;
    assign pt[1] = b192.plaintext;

    assign b256.key_valid = kv[2];
    assign b256.key_in    = key_s;
    assign b256.in_valid  = iv[2];
    assign b256.ciphertext = ct_s;
    assign b256.out_ready = ordy[2];
    assign kr[2] = b256.key_ready;
    assign ir[2] = b256.in_ready;
    assign ov[2] = b256.out_valid;
    assign pt[2] = b256.plaintext;

    typedef struct {
        int           inst;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           kexp;
        int           lat;
    } vec_t;

    localparam logic [127:0] PT_REF  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] RK10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    vec_t vecs [3];
    int   n_cmp;
    int   n_bad;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Called at a negedge: offers the key for one edge, then counts negedges with key_ready low.
    task automatic load_key(input int i, input logic [255:0] k, output int low_cycles);
        key_s = k;
        kv[i] = 1'b1;
        @(negedge clk);
        kv[i] = 1'b0;
        low_cycles = 0;
        while (!kr[i] && low_cycles < 200) begin
            low_cycles++;
            @(negedge clk);
        end
    endtask

    // Called at a negedge: offers a block for one edge, returns the edge count until out_valid.
    task automatic send_block(input int i, input logic [127:0] c, output logic [127:0] res, output int lat);
        ct_s  = c;
        iv[i] = 1'b1;
        @(negedge clk);
        iv[i] = 1'b0;
        lat = 0;
        while (!ov[i] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = pt[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lowc;
        int           lat;
        logic [127:0] got;
        logic         seen_ov;
        logic         seen_ir;

        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        key_s = '0;
        ct_s  = '0;
        for (int i = 0; i < 3; i++) begin
            kv[i]   = 1'b0;
            iv[i]   = 1'b0;
            ordy[i] = 1'b1;
        end

        vecs[0] = '{0, KEY_128, CT_128, PT_REF, 40, 10};
        vecs[1] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_REF, 46, 12};
        vecs[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089, PT_REF, 52, 14};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("inst%0d reset key_ready", i), 128'(kr[i]), 128'd1);
            check($sformatf("inst%0d reset in_ready", i),  128'(ir[i]), 128'd0);
            check($sformatf("inst%0d reset out_valid", i), 128'(ov[i]), 128'd0);
            check($sformatf("inst%0d reset plaintext", i), pt[i], 128'd0);
        end

        // Table-driven: key load, expansion length, decryption and block latency per key size.
        for (int v = 0; v < 3; v++) begin
            load_key(vecs[v].inst, vecs[v].key, lowc);
            check($sformatf("vec%0d key_ready low cycles", v), 128'(lowc), 128'(vecs[v].kexp));
            check($sformatf("vec%0d in_ready after expansion", v), 128'(ir[vecs[v].inst]), 128'd1);
            send_block(vecs[v].inst, vecs[v].ct, got, lat);
            check($sformatf("vec%0d plaintext", v), got, vecs[v].pt);
            check($sformatf("vec%0d latency", v), 128'(lat), 128'(vecs[v].lat));
        end

        check("aes128 rk10", {u128.w[40], u128.w[41], u128.w[42], u128.w[43]}, RK10);

        // Handshake completes on the next edge; the result register keeps its value.
        @(negedge clk);
        check("post-handshake out_valid", 128'(ov[0]), 128'd0);
        check("post-handshake plaintext kept", pt[0], PT_REF);

        // Backpressure: sink stalls five cycles after out_valid.
        ordy[0] = 1'b0;
        send_block(0, CT_128, got, lat);
        check("bp latency", 128'(lat), 128'd10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp cycle%0d plaintext", k), pt[0], PT_REF);
            check($sformatf("bp cycle%0d out_valid", k), 128'(ov[0]), 128'd1);
            check($sformatf("bp cycle%0d in_ready", k),  128'(ir[0]), 128'd0);
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        check("bp release out_valid", 128'(ov[0]), 128'd0);
        check("bp release in_ready", 128'(ir[0]), 128'd1);
        send_block(0, CT_128, got, lat);
        check("bp next block plaintext", got, PT_REF);
        check("bp next block latency", 128'(lat), 128'd10);
        @(negedge clk);

        // Priority: key and block offered together in READY; the key wins.
        key_s = KEY_128;
        ct_s  = CT_128;
        kv[0] = 1'b1;
        iv[0] = 1'b1;
        #1;
        check("prio in_ready", 128'(ir[0]), 128'd0);
        check("prio key_ready", 128'(kr[0]), 128'd1);
        @(negedge clk);
        kv[0] = 1'b0;
        iv[0] = 1'b0;
        check("prio key accepted", 128'(kr[0]), 128'd0);
        check("prio no block started", 128'(ov[0]), 128'd0);
        lowc = 0;
        while (!kr[0] && lowc < 200) begin
            lowc++;
            @(negedge clk);
        end
        check("prio re-expansion cycles", 128'(lowc), 128'd40);
        send_block(0, CT_128, got, lat);
        check("prio plaintext after reload", got, PT_REF);
        @(negedge clk);

        // Reset during the fifth inverse round.
        ct_s  = CT_128;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst mid-round out_valid", 128'(ov[0]), 128'd0);
        check("rst mid-round in_ready", 128'(ir[0]), 128'd0);
        check("rst mid-round key_ready", 128'(kr[0]), 128'd1);
        check("rst mid-round plaintext", pt[0], 128'd0);
        iv[0]   = 1'b1;
        seen_ov = 1'b0;
        seen_ir = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            seen_ov = seen_ov | ov[0];
            seen_ir = seen_ir | ir[0];
        end
        iv[0] = 1'b0;
        check("no accept without key in_ready", 128'(seen_ir), 128'd0);
        check("no accept without key out_valid", 128'(seen_ov), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_iter.md
# aes_decrypt_iter

Iterative, handshaked AES inverse cipher. It is the sequential, clocked counterpart of the combinational encrypt path. It accepts a key, expands it once into an internal round-key store, then decrypts one 128-bit block at a time, one inverse round per clock. It sits between a ciphertext source and a plaintext sink, and both sides use valid/ready handshakes. One parameter set covers AES-128, AES-192 and AES-256.

## Interface
- `KEY_LEN`, default 128: key width in bits (128/192/256).
- `NR`, default 10: number of rounds (10/12/14).
- `NK`, default 4: key length in 32-bit words (4/6/8).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `key_valid` in 1: `key_in` is presented.
- `key_in` in `KEY_LEN`: cipher key; MSB byte is key byte 0.
- `key_ready` out 1: key can be accepted.
- `in_valid` in 1: `ciphertext` is presented.
- `ciphertext` in 128: bits [127:120] are state byte 0, column-major per FIPS-197.
- `in_ready` out 1: block can be accepted.
- `out_valid` out 1: `plaintext` is valid.
- `plaintext` out 128: result, registered.
- `out_ready` in 1: sink accepts the result.

## Operation
- States:
  - IDLE: no valid key.
  - KEYEXP: key expansion in progress.
  - READY: keys valid, waiting for a block.
  - ROUND: inverse rounds in progress.
  - DONE: result held.
- Key accept:
  - Occurs when `key_valid && key_ready`. `key_ready` = state ∈ {IDLE, READY}.
  - `w[0..NK-1]` are loaded from `key_in`, with `w[0]` = `key_in[KEY_LEN-1 -: 32]`. State → KEYEXP.
- KEYEXP computes one word per cycle for i = NK .. 4(NR+1)-1:
  - temp = `w[i-1]`.
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/NK], 24'h0}.
  - Else if NK > 6 and i mod NK == 4: temp = SubWord(temp).
  - `w[i]` = `w[i-NK]` ^ temp.
  - After the final word, state → READY.
- Round key r = {`w[4r]`, `w[4r+1]`, `w[4r+2]`, `w[4r+3]`}.
- Block accept:
  - Occurs when `in_valid && in_ready`. `in_ready` = (state == READY) && !`key_valid`. A key offered in READY always wins over a block.
  - State register ← ciphertext ^ rk[NR]. Round counter ← NR-1. State → ROUND.
- ROUND, each cycle:
  - state ← AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[cnt]).
  - InvMixColumns is applied after AddRoundKey when cnt ≠ 0.
  - cnt decrements each cycle. At cnt == 0 the result is written to `plaintext`, `out_valid` ← 1, state → DONE.
- DONE:
  - `plaintext` and `out_valid` are held stable until `out_ready`.
  - On `out_valid && out_ready`, `out_valid` ← 0 and state → READY.
  - `plaintext` keeps its last value.
- No pipelining: at most one block is in flight.
- `key_valid` is ignored in KEYEXP, ROUND and DONE; `key_ready` = 0 there.

## Timing
- Reset values: state IDLE, `key_ready` = 1, `in_ready` = 0, `out_valid` = 0, `plaintext` = 0, round-key store invalid.
- Key expansion: 4(NR+1)-NK cycles after the accept edge. That is 40 / 46 / 52 cycles for 128 / 192 / 256. `in_ready` rises on the cycle after the last word is written.
- Block latency: with accept at edge T, `out_valid` is high from edge T+NR onward. That is 10 / 12 / 14 cycles.
- Throughput with `out_ready` held at 1: one block per NR+2 cycles. The sequence is accept, NR-1 rounds, the DONE handshake cycle, then READY.
- `rst` asserted in any state: next state is IDLE and the keys are discarded. An in-flight block is dropped with no output, and a key must be reloaded.
- `in_ready` and `key_ready` are combinational from state and `key_valid` only; they never depend on `out_ready`.

## Structure
- Shared package `aes_pkg` holds:
  - forward and inverse S-box functions;
  - the Rcon table (indices 1..10);
  - GF(2^8) xtime and multiply-by-{09, 0b, 0d, 0e};
  - the `MAX_WORDS` = 60 constant.
- Sub-module `aes_inv_round`, combinational:
  - inputs: state, round key, `last` flag;
  - behaviour: InvShiftRows → InvSubBytes → AddRoundKey → optional InvMixColumns.
- Top level holds the FSM, round counter, key-expansion word counter, and the `w[]` register array.

## Test plan
- AES-128: key 000102030405060708090a0b0c0d0e0f, then ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. Required: `plaintext` = 00112233445566778899aabbccddeeff. `key_ready` is low for 40 cycles, and `out_valid` is high exactly 10 edges after the accept edge.
- AES-128 key schedule: probe rk[10]. Required: 13111d7fe3944a17f307a78b4d2b30c5.
- AES-192 and AES-256 instances, same plaintext:
  - 192: key 00..17, ciphertext dda97ca4864cdfe06eaf70a0ec0d7191.
  - 256: key 00..1f, ciphertext 8ea2b7ca516745bfeafc49904b496089.
  - Required: plaintext 00112233445566778899aabbccddeeff, with latency 12 and 14 respectively.
- Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid`. Required: `plaintext` stable, `in_ready` = 0. Assert `out_ready`; next block is accepted in the following cycle.
- Priority: `key_valid` and `in_valid` both high in READY. Required: `in_ready` = 0, the key is accepted, and KEYEXP restarts.
- Reset mid-ROUND (cycle 5 of 10). Required: next cycle shows `out_valid` = 0, `in_ready` = 0, `key_ready` = 1. A block offered without a reload is not accepted.
